// File: rtl/axil_settings_pkg.sv
// Shared FSM state types and AXI response codes for the AXI-Lite settings bridge.
package axil_settings_pkg;

    typedef enum logic [1:0] {
        W_IDLE,
        W_STB,
        W_RESP
    } w_state_t;

    typedef enum logic [1:0] {
        R_IDLE,
        R_FETCH,
        R_RESP
    } r_state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/axil_settings_bridge.sv
// AXI4-Lite slave that turns writes into one-cycle settings-bus strobes and reads into register-bank fetches.
// Optional: define AXIL_SETTINGS_STRB_CHECK_EN to reject partial-strobe writes with SLVERR and no strobe.
module axil_settings_bridge
    import axil_settings_pkg::*;
#(
    parameter int C_DATAWIDTH = 32,
    parameter int C_ADDRWIDTH = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [C_ADDRWIDTH-1:0]     s_axi_awaddr,
    input  logic                       s_axi_awvalid,
    output logic                       s_axi_awready,
    input  logic [C_DATAWIDTH-1:0]     s_axi_wdata,
    input  logic [C_DATAWIDTH/8-1:0]   s_axi_wstrb,
    input  logic                       s_axi_wvalid,
    output logic                       s_axi_wready,
    output logic [1:0]                 s_axi_bresp,
    output logic                       s_axi_bvalid,
    input  logic                       s_axi_bready,
    input  logic [C_ADDRWIDTH-1:0]     s_axi_araddr,
    input  logic                       s_axi_arvalid,
    output logic                       s_axi_arready,
    output logic [C_DATAWIDTH-1:0]     s_axi_rdata,
    output logic [1:0]                 s_axi_rresp,
    output logic                       s_axi_rvalid,
    input  logic                       s_axi_rready,
    output logic [C_DATAWIDTH-1:0]     set_data,
    output logic [C_ADDRWIDTH-1:0]     set_addr,
    output logic                       set_stb,
    output logic [C_ADDRWIDTH-1:0]     get_addr,
    input  logic [C_DATAWIDTH-1:0]     get_data
);

    w_state_t w_state;
    r_state_t r_state;

    logic                     aw_have, w_have;
    logic [C_ADDRWIDTH-1:0]   aw_addr_q;
    logic [C_DATAWIDTH-1:0]   w_data_q;
    logic [C_DATAWIDTH/8-1:0] w_strb_q;

    logic                     aw_fire, w_fire, ar_fire;
    logic                     aw_next, w_next;
    logic [C_ADDRWIDTH-1:0]   addr_sel;
    logic [C_DATAWIDTH-1:0]   data_sel;
    logic [C_DATAWIDTH/8-1:0] strb_sel;
    logic                     strb_ok;

    assign aw_fire = s_axi_awvalid && s_axi_awready;
    assign w_fire  = s_axi_wvalid && s_axi_wready;
    assign ar_fire = s_axi_arvalid && s_axi_arready;
    assign aw_next = aw_have || aw_fire;
    assign w_next  = w_have || w_fire;

    // A channel arriving on the completing edge is taken straight from the bus.
    assign addr_sel = aw_fire ? s_axi_awaddr : aw_addr_q;
    assign data_sel = w_fire ? s_axi_wdata : w_data_q;
    assign strb_sel = w_fire ? s_axi_wstrb : w_strb_q;

`ifdef AXIL_SETTINGS_STRB_CHECK_EN
    assign strb_ok = &strb_sel;
`else
    // Strobes are ignored; the OR keeps the strobe path read so nothing dangles.
    assign strb_ok = (&strb_sel) | 1'b1;
`endif

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            w_state       <= W_IDLE;
            aw_have       <= 1'b0;
            w_have        <= 1'b0;
            aw_addr_q     <= '0;
            w_data_q      <= '0;
            w_strb_q      <= '0;
            s_axi_awready <= 1'b0;
            s_axi_wready  <= 1'b0;
            s_axi_bvalid  <= 1'b0;
            s_axi_bresp   <= RESP_OKAY;
            set_stb       <= 1'b0;
            set_addr      <= '0;
            set_data      <= '0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (aw_fire) aw_addr_q <= s_axi_awaddr;
                    if (w_fire) begin
                        w_data_q <= s_axi_wdata;
                        w_strb_q <= s_axi_wstrb;
                    end
                    if (aw_next && w_next) begin
                        w_state       <= W_STB;
                        aw_have       <= 1'b0;
                        w_have        <= 1'b0;
                        s_axi_awready <= 1'b0;
                        s_axi_wready  <= 1'b0;
                        set_addr      <= addr_sel;
                        set_data      <= data_sel;
                        set_stb       <= strb_ok;
                        s_axi_bresp   <= strb_ok ? RESP_OKAY : RESP_SLVERR;
                    end else begin
                        aw_have       <= aw_next;
                        w_have        <= w_next;
                        s_axi_awready <= !aw_next;
                        s_axi_wready  <= !w_next;
                    end
                end
                W_STB: begin
                    set_stb      <= 1'b0;
                    s_axi_bvalid <= 1'b1;
                    w_state      <= W_RESP;
                end
                W_RESP: begin
                    if (s_axi_bready) begin
                        s_axi_bvalid  <= 1'b0;
                        s_axi_awready <= 1'b1;
                        s_axi_wready  <= 1'b1;
                        w_state       <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    // Read side: address out in R_FETCH, bank reply captured on the following edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= R_IDLE;
            s_axi_arready <= 1'b0;
            s_axi_rvalid  <= 1'b0;
            s_axi_rdata   <= '0;
            s_axi_rresp   <= RESP_OKAY;
            get_addr      <= '0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (ar_fire) begin
                        get_addr      <= s_axi_araddr;
                        s_axi_arready <= 1'b0;
                        r_state       <= R_FETCH;
                    end else begin
                        s_axi_arready <= 1'b1;
                    end
                end
                R_FETCH: begin
                    s_axi_rdata  <= get_data;
                    s_axi_rresp  <= RESP_OKAY;
                    s_axi_rvalid <= 1'b1;
                    r_state      <= R_RESP;
                end
                R_RESP: begin
                    if (s_axi_rready) begin
                        s_axi_rvalid  <= 1'b0;
                        s_axi_arready <= 1'b1;
                        r_state       <= R_IDLE;
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axil_settings_bridge.sv
// Directed bench for axil_settings_bridge: cycle-stamped transaction model plus hand-computed expectations.
module tb_axil_settings_bridge;
    import axil_settings_pkg::*;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int SW = DW / 8;
`ifdef AXIL_SETTINGS_STRB_CHECK_EN
    localparam bit STRB_CHECK = 1'b1;
`else
    localparam bit STRB_CHECK = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [AW-1:0] s_axi_awaddr = '0;
    logic          s_axi_awvalid = 1'b0;
    logic          s_axi_awready;
    logic [DW-1:0] s_axi_wdata = '0;
    logic [SW-1:0] s_axi_wstrb = '1;
    logic          s_axi_wvalid = 1'b0;
    logic          s_axi_wready;
    logic [1:0]    s_axi_bresp;
    logic          s_axi_bvalid;
    logic          s_axi_bready = 1'b1;
    logic [AW-1:0] s_axi_araddr = '0;
    logic          s_axi_arvalid = 1'b0;
    logic          s_axi_arready;
    logic [DW-1:0] s_axi_rdata;
    logic [1:0]    s_axi_rresp;
    logic          s_axi_rvalid;
    logic          s_axi_rready = 1'b1;
    logic [DW-1:0] set_data;
    logic [AW-1:0] set_addr;
    logic          set_stb;
    logic [AW-1:0] get_addr;
    logic [DW-1:0] get_data;

    int n_checks = 0;
    int n_errors = 0;

    axil_settings_bridge #(.C_DATAWIDTH(DW), .C_ADDRWIDTH(AW)) dut (
        .clk(clk), .rst(rst),
        .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
        .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
        .s_axi_bready(s_axi_bready), .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid),
        .s_axi_arready(s_axi_arready), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
        .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
        .set_data(set_data), .set_addr(set_addr), .set_stb(set_stb),
        .get_addr(get_addr), .get_data(get_data)
    );

    always #5 clk = ~clk;

    // Register bank reply: fixed pattern for address 0, address-tagged words elsewhere.
    function automatic logic [DW-1:0] bank(input logic [AW-1:0] a);
        if (a == '0) return 32'hACE0BA53;
        return 32'hC0DE0000 | {16'h0000, a[15:0]};
    endfunction

    assign get_data = bank(get_addr);

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Transaction model: cycle stamps of accepted writes/reads drive every expected output.
    int            cyc = 0;
    int            w_acc = -10;
    int            r_acc = -10;
    bit            m_live = 1'b0;
    logic          aw_have, w_have, w_busy, r_busy, w_ok;
    logic [AW-1:0] q_aw;
    logic [DW-1:0] q_wd;
    logic [SW-1:0] q_ws;
    logic          m_awready, m_wready, m_arready, m_bvalid, m_rvalid, m_set_stb;
    logic [1:0]    m_bresp;
    logic [AW-1:0] m_set_addr, m_get_addr;
    logic [DW-1:0] m_set_data, m_rdata;
    int            stb_count = 0;
    int            stb_cyc[$];

    task automatic model_step();
        logic aw_fire, w_fire, ar_fire;
        if (set_stb === 1'b1) begin
            stb_count++;
            stb_cyc.push_back(cyc);
        end
        cyc++;
        if (rst) begin
            m_live = 1'b1;
            aw_have = 1'b0; w_have = 1'b0; w_busy = 1'b0; r_busy = 1'b0; w_ok = 1'b1;
            w_acc = -10; r_acc = -10;
            m_awready = 1'b0; m_wready = 1'b0; m_arready = 1'b0;
            m_bvalid = 1'b0; m_rvalid = 1'b0; m_set_stb = 1'b0;
            m_bresp = RESP_OKAY;
            m_set_addr = '0; m_set_data = '0; m_get_addr = '0; m_rdata = '0;
        end else begin
            aw_fire = s_axi_awvalid && m_awready;
            w_fire  = s_axi_wvalid && m_wready;
            ar_fire = s_axi_arvalid && m_arready;
            if (m_bvalid && s_axi_bready) begin
                m_bvalid = 1'b0;
                w_busy   = 1'b0;
            end
            if (w_acc == cyc - 1) begin
                m_bvalid = 1'b1;
                m_bresp  = w_ok ? RESP_OKAY : RESP_SLVERR;
            end
            if (aw_fire) begin aw_have = 1'b1; q_aw = s_axi_awaddr; end
            if (w_fire) begin w_have = 1'b1; q_wd = s_axi_wdata; q_ws = s_axi_wstrb; end
            if (aw_have && w_have) begin
                w_acc = cyc; w_busy = 1'b1;
                m_set_addr = q_aw; m_set_data = q_wd;
                w_ok = !STRB_CHECK || (q_ws == '1);
                aw_have = 1'b0; w_have = 1'b0;
            end
            m_awready = !w_busy && !aw_have;
            m_wready  = !w_busy && !w_have;
            m_set_stb = (w_acc == cyc) && w_ok;

            if (m_rvalid && s_axi_rready) begin
                m_rvalid = 1'b0;
                r_busy   = 1'b0;
            end
            if (r_acc == cyc - 1) begin
                m_rvalid = 1'b1;
                m_rdata  = bank(m_get_addr);
            end
            if (ar_fire) begin r_busy = 1'b1; r_acc = cyc; m_get_addr = s_axi_araddr; end
            m_arready = !r_busy;
        end
    endtask

    always @(posedge clk) model_step();

    always @(negedge clk) begin
        if (m_live) begin
            check("awready", s_axi_awready, m_awready);
            check("wready", s_axi_wready, m_wready);
            check("arready", s_axi_arready, m_arready);
            check("bvalid", s_axi_bvalid, m_bvalid);
            check("rvalid", s_axi_rvalid, m_rvalid);
            check("set_stb", set_stb, m_set_stb);
            check("set_addr", set_addr, m_set_addr);
            check("set_data", set_data, m_set_data);
            check("get_addr", get_addr, m_get_addr);
            if (m_bvalid) check("bresp", s_axi_bresp, m_bresp);
            if (m_rvalid) begin
                check("rdata", s_axi_rdata, m_rdata);
                check("rresp", s_axi_rresp, RESP_OKAY);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_aw(input logic [AW-1:0] a, input int dly);
        logic seen;
        seen = 1'b0;
        repeat (dly) tick();
        s_axi_awaddr  = a;
        s_axi_awvalid = 1'b1;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = s_axi_awready;
            tick();
        end
        s_axi_awvalid = 1'b0;
        check("aw_handshake", seen, 1'b1);
    endtask

    task automatic send_w(input logic [DW-1:0] d, input logic [SW-1:0] s, input int dly);
        logic seen;
        seen = 1'b0;
        repeat (dly) tick();
        s_axi_wdata  = d;
        s_axi_wstrb  = s;
        s_axi_wvalid = 1'b1;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = s_axi_wready;
            tick();
        end
        s_axi_wvalid = 1'b0;
        check("w_handshake", seen, 1'b1);
    endtask

    task automatic send_ar(input logic [AW-1:0] a);
        logic seen;
        seen = 1'b0;
        s_axi_araddr  = a;
        s_axi_arvalid = 1'b1;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = s_axi_arready;
            tick();
        end
        s_axi_arvalid = 1'b0;
        check("ar_handshake", seen, 1'b1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected bench completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base;

        // Reset values
        repeat (3) tick();
        @(negedge clk);
        check("rst_awready", s_axi_awready, 1'b0);
        check("rst_wready", s_axi_wready, 1'b0);
        check("rst_arready", s_axi_arready, 1'b0);
        check("rst_bvalid", s_axi_bvalid, 1'b0);
        check("rst_rvalid", s_axi_rvalid, 1'b0);
        check("rst_set_stb", set_stb, 1'b0);
        check("rst_set_addr", set_addr, 32'h0);
        check("rst_set_data", set_data, 32'h0);
        check("rst_get_addr", get_addr, 32'h0);
        check("rst_rdata", s_axi_rdata, 32'h0);
        check("rst_bresp", s_axi_bresp, 2'b00);
        check("rst_rresp", s_axi_rresp, 2'b00);
        tick();
        rst = 1'b0;
        tick();
        @(negedge clk);
        check("post_rst_awready", s_axi_awready, 1'b1);
        check("post_rst_wready", s_axi_wready, 1'b1);
        check("post_rst_arready", s_axi_arready, 1'b1);
        tick();

        // Simultaneous AW/W
        fork
            send_aw(32'h004, 0);
            send_w(32'h0000001A, 4'hF, 0);
        join
        @(negedge clk);
        check("t1_stb", set_stb, 1'b1);
        check("t1_addr", set_addr, 32'h004);
        check("t1_data", set_data, 32'h1A);
        tick();
        @(negedge clk);
        check("t1_stb_one_cycle", set_stb, 1'b0);
        check("t1_bvalid", s_axi_bvalid, 1'b1);
        check("t1_bresp", s_axi_bresp, 2'b00);
        repeat (2) tick();

        // W three cycles ahead of AW
        base = stb_count;
        fork
            send_w(32'h5, 4'hF, 0);
            send_aw(32'h008, 3);
        join
        @(negedge clk);
        check("t2_stb", set_stb, 1'b1);
        check("t2_addr", set_addr, 32'h008);
        check("t2_data", set_data, 32'h5);
        repeat (3) tick();
        check("t2_single_stb", stb_count, base + 1);

        // Read with rready stalled for four cycles
        s_axi_rready = 1'b0;
        send_ar(32'h000);
        @(negedge clk);
        check("t3_get_addr", get_addr, 32'h0);
        check("t3_rvalid_fetch", s_axi_rvalid, 1'b0);
        tick();
        @(negedge clk);
        check("t3_rvalid", s_axi_rvalid, 1'b1);
        check("t3_rdata", s_axi_rdata, 32'hACE0BA53);
        for (int i = 0; i < 4; i++) begin
            tick();
            @(negedge clk);
            check("t3_rvalid_hold", s_axi_rvalid, 1'b1);
            check("t3_rdata_hold", s_axi_rdata, 32'hACE0BA53);
        end
        s_axi_rready = 1'b1;
        tick();
        @(negedge clk);
        check("t3_rvalid_drop", s_axi_rvalid, 1'b0);
        tick();

        // Concurrent write and read
        fork
            send_aw(32'h010, 0);
            send_w(32'hDEAD0010, 4'hF, 0);
            send_ar(32'h01C);
        join
        @(negedge clk);
        check("t4_stb", set_stb, 1'b1);
        check("t4_addr", set_addr, 32'h010);
        check("t4_get_addr", get_addr, 32'h01C);
        tick();
        @(negedge clk);
        check("t4_bvalid", s_axi_bvalid, 1'b1);
        check("t4_rvalid", s_axi_rvalid, 1'b1);
        check("t4_rdata", s_axi_rdata, 32'hC0DE001C);
        repeat (2) tick();

        // Reset pulsed while the response is pending
        s_axi_bready = 1'b0;
        base = stb_count;
        fork
            send_aw(32'h020, 0);
            send_w(32'h77, 4'hF, 0);
        join
        tick();
        @(negedge clk);
        check("t5_bvalid_pending", s_axi_bvalid, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("t5_bvalid_abort", s_axi_bvalid, 1'b0);
        check("t5_awready_in_rst", s_axi_awready, 1'b0);
        tick();
        @(negedge clk);
        check("t5_awready_after", s_axi_awready, 1'b1);
        s_axi_bready = 1'b1;
        repeat (3) tick();
        check("t5_stb_count", stb_count, base + 1);

        // Back-to-back writes alongside back-to-back reads
        fork
            for (int i = 0; i < 3; i++) begin
                fork
                    send_aw(32'h100 + 32'(4 * i), 0);
                    send_w(32'hA0 + 32'(i), 4'hF, 0);
                join
            end
            for (int j = 0; j < 3; j++) send_ar(32'h200 + 32'(4 * j));
        join
        repeat (4) tick();
        check("t6_gap_a", stb_cyc[$] - stb_cyc[$-1], 3);
        check("t6_gap_b", stb_cyc[$-1] - stb_cyc[$-2], 3);

        // Partial strobes, then a full-strobe write
        fork
            send_aw(32'h030, 0);
            send_w(32'h1234, 4'b0111, 0);
        join
        @(negedge clk);
        check("t7_partial_stb", set_stb, STRB_CHECK ? 1'b0 : 1'b1);
        tick();
        @(negedge clk);
        check("t7_partial_bresp", s_axi_bresp, STRB_CHECK ? 2'b10 : 2'b00);
        repeat (2) tick();
        fork
            send_aw(32'h034, 0);
            send_w(32'h5678, 4'b1111, 0);
        join
        @(negedge clk);
        check("t7_full_stb", set_stb, 1'b1);
        tick();
        @(negedge clk);
        check("t7_full_bresp", s_axi_bresp, 2'b00);
        repeat (3) tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
